// File: rtl/shared_mem_responder.sv
// Shared block memory responder for the icache and dcache.
// Arbitrates round-robin between the caches and serves one block per LATENCY access cycles.
module shared_mem_responder #(
    parameter int LATENCY = 5,
    parameter int DEPTH   = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_read,
    input  logic [27:0]  i_address,
    output logic [127:0] i_readdata,
    output logic         i_busywait,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [27:0]  d_address,
    input  logic [127:0] d_writedata,
    output logic [127:0] d_readdata,
    output logic         d_busywait
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CntInit = 4'(LATENCY - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] D_BUSY = 3'd1;
    localparam logic [2:0] I_BUSY = 3'd2;
    localparam logic [2:0] D_DONE = 3'd3;
    localparam logic [2:0] I_DONE = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          lastGrant_q, lastGrant_d;
    logic [127:0]  mem [DEPTH];

    logic          dReq;
    logic          dAccess;
    logic          iAccess;
    logic [AW-1:0] dIdx;
    logic [AW-1:0] iIdx;
    logic          unusedAddrBits;

    assign dReq    = d_read | d_write;
    assign dAccess = (state_q == D_BUSY) && (cnt_q == 4'd0);
    assign iAccess = (state_q == I_BUSY) && (cnt_q == 4'd0);
    assign dIdx    = d_address[AW-1:0];
    assign iIdx    = i_address[AW-1:0];
    assign unusedAddrBits = ^{i_address[27:AW], d_address[27:AW]};

    assign d_busywait = dReq && (state_q != D_DONE);
    assign i_busywait = i_read && (state_q != I_DONE);

    // lastGrant_q == 1 means the icache won last, so the dcache wins a tie next.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lastGrant_d = lastGrant_q;
        case (state_q)
            IDLE: begin
                if (dReq && (!i_read || lastGrant_q)) begin
                    state_d     = D_BUSY;
                    cnt_d       = CntInit;
                    lastGrant_d = 1'b0;
                end else if (i_read) begin
                    state_d     = I_BUSY;
                    cnt_d       = CntInit;
                    lastGrant_d = 1'b1;
                end
            end
            D_BUSY: begin
                if (cnt_q == 4'd0) state_d = D_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            I_BUSY: begin
                if (cnt_q == 4'd0) state_d = I_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            lastGrant_q <= 1'b1;
            i_readdata  <= '0;
            d_readdata  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lastGrant_q <= lastGrant_d;
            if (dAccess && !d_write) d_readdata <= mem[dIdx];
            if (iAccess)             i_readdata <= mem[iIdx];
        end
    end

    // The array is never reset; the reset gate keeps an interrupted write from landing.
    always_ff @(posedge clk) begin
        if (dAccess && d_write && !reset) mem[dIdx] <= d_writedata;
    end

endmodule

// File: tb/tb_shared_mem_responder.sv
// Directed bench for shared_mem_responder: a transaction table plus hand-written
// sequences for arbitration, mid-access reset and the LATENCY=1 corner.
module tb_shared_mem_responder;

    typedef struct {
        logic         isI;
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] expData;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         iRead = 1'b0;
    logic [27:0]  iAddress = '0;
    logic [127:0] iReaddata;
    logic         iBusywait;
    logic         dRead = 1'b0;
    logic         dWrite = 1'b0;
    logic [27:0]  dAddress = '0;
    logic [127:0] dWritedata = '0;
    logic [127:0] dReaddata;
    logic         dBusywait;

    logic         bIRead = 1'b0;
    logic [27:0]  bIAddress = '0;
    logic [127:0] bIReaddata;
    logic         bIBusywait;
    logic         bDRead = 1'b0;
    logic         bDWrite = 1'b0;
    logic [27:0]  bDAddress = '0;
    logic [127:0] bDWritedata = '0;
    logic [127:0] bDReaddata;
    logic         bDBusywait;

    int total = 0;
    int bad = 0;

    localparam logic [127:0] PatA5 = {16{8'hA5}};
    localparam logic [127:0] Pat33 = {16{8'h33}};
    localparam logic [127:0] PatBE = {8{16'hBEEF}};
    localparam logic [127:0] Pat77 = {16{8'h77}};
    localparam logic [127:0] Pat11 = {16{8'h11}};
    localparam logic [127:0] Pat55 = {16{8'h55}};

    shared_mem_responder #(.LATENCY(5), .DEPTH(256)) dut (
        .clk(clk), .reset(reset),
        .i_read(iRead), .i_address(iAddress), .i_readdata(iReaddata), .i_busywait(iBusywait),
        .d_read(dRead), .d_write(dWrite), .d_address(dAddress), .d_writedata(dWritedata),
        .d_readdata(dReaddata), .d_busywait(dBusywait)
    );

    shared_mem_responder #(.LATENCY(1), .DEPTH(16)) dutFast (
        .clk(clk), .reset(reset),
        .i_read(bIRead), .i_address(bIAddress), .i_readdata(bIReaddata), .i_busywait(bIBusywait),
        .d_read(bDRead), .d_write(bDWrite), .d_address(bDAddress), .d_writedata(bDWritedata),
        .d_readdata(bDReaddata), .d_busywait(bDBusywait)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Drives one request, counts the cycles busywait stays high, then checks latency and data.
    task automatic applyStimulus(input vec_t v, input string name);
        int cycles;
        logic [127:0] rdata;
        @(negedge clk);
        if (v.isI) begin
            iAddress = v.addr;
            iRead    = 1'b1;
        end else begin
            dAddress   = v.addr;
            dWritedata = v.wdata;
            dRead      = v.rd;
            dWrite     = v.wr;
        end
        cycles = 0;
        #1;
        while ((v.isI ? iBusywait : dBusywait) && cycles < 100) begin
            cycles++;
            @(negedge clk);
            #1;
        end
        rdata  = v.isI ? iReaddata : dReaddata;
        iRead  = 1'b0;
        dRead  = 1'b0;
        dWrite = 1'b0;
        checkOutput({name, "_cycles"}, 128'(cycles), 128'd6);
        checkOutput({name, "_data"}, rdata, v.expData);
    endtask

    vec_t vecs[10];

    initial begin
        int dDone, iDone, n, cycles;
        int evC[3];
        logic evI[3];
        logic [127:0] dData, iData;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 28'h10,        PatA5, 128'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 28'h10,        '0,    PatA5};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 28'h10,        '0,    PatA5};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 28'h3,         Pat33, PatA5};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 28'h103,       '0,    Pat33};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 28'hFFFFF03,   '0,    Pat33};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 28'h20,        PatBE, Pat33};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 28'h20,        '0,    PatBE};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 28'h20,        Pat77, Pat33};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 28'h20,        '0,    Pat77};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_i_readdata", iReaddata, 128'd0);
        checkOutput("reset_d_readdata", dReaddata, 128'd0);
        checkOutput("reset_d_busywait", 128'(dBusywait), 128'd0);
        checkOutput("reset_i_busywait", 128'(iBusywait), 128'd0);

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous first requests after reset: dcache wins, icache follows.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        dAddress = 28'h10;
        iAddress = 28'h20;
        dRead = 1'b1;
        iRead = 1'b1;
        dDone = -1;
        iDone = -1;
        dData = '0;
        iData = '0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (dRead && !dBusywait) begin dDone = c; dData = dReaddata; dRead = 1'b0; end
            if (iRead && !iBusywait) begin iDone = c; iData = iReaddata; iRead = 1'b0; end
            if (!dRead && !iRead) break;
            @(negedge clk);
        end
        dRead = 1'b0;
        iRead = 1'b0;
        checkOutput("tie_d_done_cycle", 128'(dDone), 128'd6);
        checkOutput("tie_i_done_cycle", 128'(iDone), 128'd13);
        checkOutput("tie_d_data", dData, PatA5);
        checkOutput("tie_i_data", iData, Pat77);

        // Both sides hold their requests: grants must alternate D, I, D.
        @(negedge clk);
        dRead = 1'b1;
        iRead = 1'b1;
        n = 0;
        for (int k = 0; k < 3; k++) begin evC[k] = -1; evI[k] = 1'bx; end
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!dBusywait && n < 3) begin evI[n] = 1'b0; evC[n] = c; n++; end
            if (!iBusywait && n < 3) begin evI[n] = 1'b1; evC[n] = c; n++; end
            if (n == 3) break;
            @(negedge clk);
        end
        dRead = 1'b0;
        iRead = 1'b0;
        checkOutput("rr_grant0_side", 128'(evI[0]), 128'd0);
        checkOutput("rr_grant1_side", 128'(evI[1]), 128'd1);
        checkOutput("rr_grant2_side", 128'(evI[2]), 128'd0);
        checkOutput("rr_grant0_cycle", 128'(evC[0]), 128'd6);
        checkOutput("rr_grant1_cycle", 128'(evC[1]), 128'd13);
        checkOutput("rr_grant2_cycle", 128'(evC[2]), 128'd20);

        // Reset during cycle 3 of a write: outputs clear and the write is dropped.
        @(negedge clk);
        dAddress   = 28'h10;
        dWritedata = Pat11;
        dWrite     = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midreset_d_readdata", dReaddata, 128'd0);
        checkOutput("midreset_i_readdata", iReaddata, 128'd0);
        dWrite = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        applyStimulus('{1'b0, 1'b1, 1'b0, 28'h10, '0, PatA5}, "midreset_readback");

        // LATENCY=1 instance: write, then held back-to-back reads of three cycles each.
        @(negedge clk);
        bDAddress   = 28'h15;
        bDWritedata = Pat55;
        bDWrite     = 1'b1;
        cycles = 0;
        #1;
        while (bDBusywait && cycles < 20) begin
            cycles++;
            @(negedge clk);
            #1;
        end
        bDWrite = 1'b0;
        checkOutput("fast_write_cycles", 128'(cycles), 128'd2);
        @(negedge clk);
        bDRead = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            checkOutput($sformatf("fast_busy_c%0d", c), 128'(bDBusywait), 128'((c % 3) != 2));
            if ((c % 3) == 2) checkOutput($sformatf("fast_data_c%0d", c), bDReaddata, Pat55);
            @(negedge clk);
        end
        bDRead = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shared_mem_responder.md
SHARED_MEM_RESPONDER -- requirements
Module: shared_mem_responder

Interface
REQ-001 The module SHALL have parameter LATENCY, default 5, giving the number of access cycles per block transfer (legal range 1..15).
REQ-002 The module SHALL have parameter DEPTH, default 256, giving the number of 128-bit blocks in the backing array (power of two).
REQ-003 The module SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 Ports SHALL be:
  clk  in  1  clock, rising edge.
  reset  in  1  asynchronous active-high reset.
  i_read  in  1  icache block-read request, held until its busywait drops.
  i_address  in  28  icache block address.
  i_readdata  out  128  icache block returned.
  i_busywait  out  1  icache stall.
  d_read  in  1  dcache block-read request.
  d_write  in  1  dcache block-write (writeback) request.
  d_address  in  28  dcache block address.
  d_writedata  in  128  dcache block to write.
  d_readdata  out  128  dcache block returned.
  d_busywait  out  1  dcache stall.

Function
REQ-005 The block SHALL be the responder for the icache and dcache miss and writeback requests, with one shared backing array.
REQ-006 The FSM SHALL have states IDLE, D_BUSY, I_BUSY, D_DONE and I_DONE, plus a 4-bit down-counter cnt and a 1-bit last_grant flag (0 = dcache, 1 = icache).
REQ-007 In IDLE with only a dcache request (d_read|d_write) pending, the FSM SHALL go to D_BUSY with cnt=LATENCY-1.
REQ-008 In IDLE with only i_read pending, the FSM SHALL go to I_BUSY with cnt=LATENCY-1.
REQ-009 In IDLE with both requests pending, the FSM SHALL grant the side not recorded in last_grant (round-robin), then update last_grant to the granted side.
REQ-010 In IDLE with a single request, last_grant SHALL still be updated to the granted side.
REQ-011 In x_BUSY, cnt SHALL decrement on each edge.
REQ-012 On the edge in x_BUSY where cnt==0, the access SHALL be performed and the FSM SHALL enter x_DONE.
REQ-013 A dcache read access SHALL register array[d_address mod DEPTH] into d_readdata.
REQ-014 A dcache write access SHALL store d_writedata into array[d_address mod DEPTH].
REQ-015 An icache access SHALL register array[i_address mod DEPTH] into i_readdata.
REQ-016 x_DONE SHALL last exactly one cycle and then return to IDLE unconditionally; requests present during x_DONE SHALL NOT be granted in that cycle.
REQ-017 d_busywait SHALL be (d_read|d_write) && state!=D_DONE (combinational), so a requester stalls in the same cycle it requests.
REQ-018 i_busywait SHALL be i_read && state!=I_DONE.
REQ-019 Latency: for a request first seen in IDLE in cycle 0, busywait SHALL be high in cycles 0..LATENCY and low in cycle LATENCY+1, with readdata valid in that cycle.
REQ-020 A requester blocked by the other side's grant SHALL keep busywait high until its own x_DONE cycle.
REQ-021 If d_read and d_write are asserted together, the write SHALL take effect and d_readdata SHALL be left unchanged.
REQ-022 Address, data and request inputs SHALL be sampled at the access edge (cnt==0), not at the grant edge.
REQ-023 A request dropped before its access edge SHALL still complete the access (no abort); the x_DONE cycle then has no effect on busywait.
REQ-024 i_readdata and d_readdata SHALL hold their last values until that side's next read access.

Reset
REQ-025 Reset SHALL force state=IDLE, cnt=0, last_grant=1 (dcache wins the first tie), i_readdata=0 and d_readdata=0, asynchronously, including mid-access.
REQ-026 Reset SHALL NOT clear the backing array; an in-flight write interrupted by reset SHALL NOT be committed.

Verification
REQ-027 Write 0xA5..A5 to block 0x10, then read it back (LATENCY=5) -> d_busywait high for 6 cycles each time; the read returns 0xA5..A5 in cycle 6.
REQ-028 d_read and i_read rise in the same cycle after reset -> the dcache is served first (DONE in cycle 6) and the icache DONE follows in cycle 13; i_busywait stays high for cycles 0..12.
REQ-029 Three consecutive simultaneous conflicts -> grants alternate D, I, D with no starvation.
REQ-030 Read block address DEPTH+3 -> returns the contents of block 3 (wrap-around).
REQ-031 Assert reset in cycle 3 of a dcache write -> outputs are zero, state is IDLE, and a later read of that block returns the old value.
REQ-032 Set LATENCY=1, then issue back-to-back dcache reads with the request held through DONE -> busywait is low exactly one cycle per access and each access takes 3 cycles (grant, access, DONE).
